// File: rtl/cordic_range_reduce.sv
// Iterative argument reduction for the CORDIC cosine core: float radians -> Q8.22,
// mod 2*pi by conditional subtraction, then fold into [0, pi/2] with a negate flag.
module cordic_range_reduce #(
  parameter int unsigned FRAC_BITS = 22,
  parameter int unsigned RED_STEPS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [31:0]          dataa,
  output logic                 busy,
  output logic                 done,
  output logic [FRAC_BITS+1:0] z,
  output logic                 neg,
  output logic                 err
);

  localparam int unsigned R_W = FRAC_BITS + 8;
  localparam int unsigned C_W = R_W + 1;
  localparam int unsigned K_W = $clog2(RED_STEPS);
  localparam int unsigned Z_W = FRAC_BITS + 2;

  localparam logic [R_W-1:0] TWO_PI  = R_W'(32'h1921FB5);
  localparam logic [R_W-1:0] PI      = R_W'(32'h0C90FDB);
  localparam logic [R_W-1:0] HALF_PI = R_W'(32'h06487ED);

  typedef enum logic [1:0] {S_IDLE, S_RED, S_FOLD, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [R_W-1:0] r_q, r_d;
  logic           err_in_q, err_in_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [Z_W-1:0] z_q, z_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;

  // Float to Q8.22 conversion; the sign is dropped because cos is even
  logic [7:0]     exp_w;
  logic [7:0]     rsh;
  logic [23:0]    mag;
  logic [R_W-1:0] cvt_r;
  logic           cvt_err;
  logic           sign_unused;

  assign sign_unused = dataa[31];

  always_comb begin
    exp_w   = dataa[30:23];
    mag     = {1'b1, dataa[22:0]};
    rsh     = 8'(8'd128 - exp_w);
    cvt_r   = '0;
    cvt_err = 1'b0;
    if (exp_w >= 8'd135) begin
      cvt_err = 1'b1;
    end else if (exp_w >= 8'd128) begin
      // exponent is 128..134 here, so its low three bits are the left shift
      cvt_r = R_W'(mag) << exp_w[2:0];
    end else if (exp_w >= 8'd105) begin
      cvt_r = R_W'(mag) >> rsh;
    end
  end

  // One conditional subtraction of TWO_PI << k
  logic [C_W-1:0] sub_k;
  logic [C_W-1:0] r_ext;
  logic [R_W-1:0] red_r;

  always_comb begin
    sub_k = C_W'(TWO_PI) << k_q;
    r_ext = C_W'(r_q);
    red_r = (r_ext >= sub_k) ? R_W'(r_ext - sub_k) : r_q;
  end

  // Fold [0, 2*pi) into [0, pi/2]
  logic [R_W-1:0] fold1;
  logic [R_W-1:0] fold2;
  logic           fold_neg;
  logic [Z_W-1:0] fold_z;
  logic           fold_unused;

  always_comb begin
    fold1    = (r_q > PI) ? R_W'(TWO_PI - r_q) : r_q;
    fold_neg = (fold1 > HALF_PI);
    fold2    = fold_neg ? R_W'(PI - fold1) : fold1;
    fold_z   = {1'b0, fold2[FRAC_BITS:0]};
  end

  assign fold_unused = |fold2[R_W-1:FRAC_BITS+1];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    err_in_d = err_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    z_d      = z_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d      = cvt_r;
          err_in_d = cvt_err;
          k_d      = K_W'(RED_STEPS - 1);
          busy_d   = 1'b1;
          state_d  = S_RED;
        end
      end
      S_RED: begin
        r_d = red_r;
        k_d = k_q - K_W'(1);
        if (k_q == '0) begin
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        z_d     = err_in_q ? '0 : fold_z;
        neg_d   = ~err_in_q & fold_neg;
        err_d   = err_in_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      r_q      <= '0;
      err_in_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      k_q      <= k_d;
      r_q      <= r_d;
      err_in_q <= err_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      z_q      <= z_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Bench for cordic_range_reduce: directed and random angles against an arithmetic model.
module tb_cordic_range_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        busy;
  logic        done;
  logic [23:0] z;
  logic        neg;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  localparam longint unsigned TWO_PI  = 64'h1921FB5;
  localparam longint unsigned PI      = 64'h0C90FDB;
  localparam longint unsigned HALF_PI = 64'h06487ED;

  cordic_range_reduce dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .busy   (busy),
    .done   (done),
    .z      (z),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {err, neg, z}: exact scaling, true modulo, then quadrant fold
  function automatic logic [25:0] model(input logic [31:0] a);
    int unsigned     e;
    longint unsigned mag;
    longint unsigned r;
    logic            ng;
    e   = a[30:23];
    mag = {1'b1, a[22:0]};
    if (e >= 135) return {1'b1, 1'b0, 24'h0};
    if (e >= 128)      r = mag << (e - 128);
    else if (e >= 105) r = mag >> (128 - e);
    else               r = 0;
    r  = r % TWO_PI;
    if (r > PI) r = TWO_PI - r;
    ng = (r > HALF_PI);
    if (ng) r = PI - r;
    return {1'b0, ng, 24'(r)};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [25:0] exp, input int stall_at,
                        input int stall_len, input bit extra_start, input bit done_stall);
    int t;
    int n;
    int left;
    dataa  = a;
    start  = 1'b1;
    clk_en = 1'b1;
    step();
    start = 1'b0;
    dataa = $urandom;
    t     = 1;
    n     = 1;
    left  = stall_len;
    while (done !== 1'b1 && t < 60) begin
      chk("busy_mid", 32'(busy), 32'd1);
      if (n == stall_at && left > 0) begin
        clk_en = 1'b0;
        left--;
      end else begin
        clk_en = 1'b1;
        start  = extra_start && (n == 2);
        n++;
      end
      step();
      t++;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    chk("done_seen", 32'(done), 32'd1);
    chk("done_cycle", 32'(t), 32'(8 + stall_len));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("z", 32'(z), 32'(exp[23:0]));
    chk("neg", 32'(neg), 32'(exp[24]));
    chk("err", 32'(err), 32'(exp[25]));
    if (done_stall) begin
      clk_en = 1'b0;
      step();
      step();
      chk("done_hold", 32'(done), 32'd1);
      chk("z_hold_stall", 32'(z), 32'(exp[23:0]));
      clk_en = 1'b1;
    end
    step();
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("z_hold", 32'(z), 32'(exp[23:0]));
    chk("neg_hold", 32'(neg), 32'(exp[24]));
    if (extra_start) begin
      for (int i = 0; i < 12; i++) begin
        step();
        chk("no_second_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic reset_mid_op();
    dataa  = 32'h40E00000;
    start  = 1'b1;
    clk_en = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t < 4; t++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  e;
    int          stall_len;
    rst    = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = 32'h0;
    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_z", 32'(z), 32'd0);
    chk("reset_neg", 32'(neg), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    run_op(32'h00000000, {1'b0, 1'b0, 24'h000000}, 0, 0, 1'b0, 1'b0);
    run_op(32'h3F800000, {1'b0, 1'b0, 24'h400000}, 0, 0, 1'b0, 1'b0);
    run_op(32'hBF800000, {1'b0, 1'b0, 24'h400000}, 0, 0, 1'b0, 1'b0);
    run_op(32'h40E00000, {1'b0, 1'b0, 24'h2DE04B}, 0, 0, 1'b0, 1'b0);
    run_op(32'h40400000, {1'b0, 1'b1, 24'h090FDB}, 0, 0, 1'b0, 1'b0);
    run_op(32'h40490FDB, {1'b0, 1'b1, 24'h000000}, 0, 0, 1'b0, 1'b0);
    run_op(32'h43800000, {1'b1, 1'b0, 24'h000000}, 0, 0, 1'b0, 1'b0);
    run_op(32'h7FC00000, {1'b1, 1'b0, 24'h000000}, 0, 0, 1'b0, 1'b0);
    run_op(32'h40E00000, {1'b0, 1'b0, 24'h2DE04B}, 3, 3, 1'b1, 1'b1);
    run_op(32'h437F0000, model(32'h437F0000), 0, 0, 1'b0, 1'b0);
    run_op(32'h3FC90FDB, model(32'h3FC90FDB), 0, 0, 1'b0, 1'b0);

    reset_mid_op();
    run_op(32'h40400000, {1'b0, 1'b1, 24'h090FDB}, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) e = 8'($urandom_range(0, 255));
      else                           e = 8'($urandom_range(100, 136));
      a = {1'($urandom), e, 23'($urandom)};
      stall_len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_op(a, model(a), $urandom_range(1, 7), stall_len,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_range_reduce.md
# cordic_range_reduce

Iterative argument-reduction stage that sits directly upstream of the combinational CORDIC cosine block. It accepts an IEEE-754 single-precision angle in radians, converts it to fixed point, reduces it modulo 2π and folds it into [0, π/2]. It outputs a 24-bit Q1.1.22 angle `z` that the CORDIC core consumes directly, plus a `neg` flag telling the downstream logic to negate the cosine. Operation is multi-cycle with a start/done handshake gated by `clk_en`, matching the custom-instruction style used in the rest of the datapath.

## Interface
- `FRAC_BITS`, 22, fractional bits of all internal fixed-point values and of `z`.
- `RED_STEPS`, 6, number of conditional-subtract steps; covers |x| < 256.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clk_en` in 1: state, counters and registers advance only when high; when low, everything holds.
- `start` in 1: begin an operation; sampled only in IDLE with `clk_en`=1.
- `dataa` in 32: IEEE-754 single angle (radians); captured on the accepted `start`.
- `busy` out 1: high from the cycle after an accepted start until `done` inclusive.
- `done` out 1: single-cycle pulse; `z`, `neg`, `err` are valid in this cycle and hold until the next accepted start.
- `z` out 24: reduced angle, Q1.1.22 (sign, 1 integer bit, 22 fraction bits); sign always 0; range [0, 0x6487ED].
- `neg` out 1: cos(dataa) = −cos(z) when high.
- `err` out 1: input out of range (exponent ≥ 135, which includes Inf/NaN).

## Operation
- Constants (Q.22): TWO_PI = 0x1921FB5, PI = 0xC90FDB, HALF_PI = 0x6487ED.
- **Capture and convert (on the accepted start edge):**
  - Ignore the sign bit, because cos is even.
  - Exponent e, mantissa mag = {1, m[22:0]} (24 bits).
  - Fixed value r (30-bit unsigned Q8.22):
    - e ≥ 128: r = mag << (e−128).
    - 105 ≤ e < 128: r = mag >> (128−e), truncated.
    - e ≤ 104, including zero and denormals: r = 0.
  - e ≥ 135: r = 0 and err_reg = 1. The operation still runs its full length.
- **FSM:** IDLE → RED (6 cycles, k = 5 down to 0) → FOLD (1 cycle) → DONE (1 cycle) → IDLE.
- **RED step k:** if r ≥ (TWO_PI << k), then r ← r − (TWO_PI << k). Compare and subtract are 31 bits wide, unsigned. After k = 0, r ∈ [0, TWO_PI).
- **FOLD**, in one combinational chain registered at the end of the cycle:
  - If r > PI: r ← TWO_PI − r. Now r ∈ [0, PI].
  - If r > HALF_PI: r ← PI − r and neg ← 1; else neg ← 0.
  - z ← {1'b0, r[22:0]}.
- If err_reg is set, z = 0 and neg = 0 are forced at FOLD.
- `start` while busy is ignored; it is not queued.
- `rst` in any state: return to IDLE with busy = 0, done = 0, z = 0, neg = 0, err = 0. An aborted operation never produces `done`.

## Timing
- Counting only cycles with `clk_en` = 1, and with start accepted in cycle 0: busy = 1 in cycles 1–8, RED in cycles 1–6, FOLD in cycle 7, done = 1 in cycle 8.
- Fixed latency of 8 enabled cycles for every input, err included.
- A new start can be accepted in the cycle after `done`.
- Cycles with `clk_en` = 0 extend the latency one-for-one. If `done` is held during such a stall, it remains high until the next enabled edge, so it still counts as one enabled cycle.
- `done`, `busy`, `z`, `neg` and `err` are all registered outputs with no combinational path from inputs.
- Reset values: busy 0, done 0, z 0x000000, neg 0, err 0.

## Test plan
- dataa = 0x00000000 (0.0), start pulse → done in enabled cycle 8, z = 0x000000, neg = 0, err = 0.
- dataa = 0x3F800000 (1.0), then 0xBF800000 (−1.0) → both give z = 0x400000, neg = 0. The second start is issued the cycle after the first `done`.
- dataa = 0x40E00000 (7.0) → one RED subtract at k = 0, z = 0x2DE04B, neg = 0. Also dataa = 0x40400000 (3.0) → z = 0x090FDB, neg = 1.
- dataa = 0x40490FDB (π) → z = 0x000000, neg = 1. Also dataa = 0x43800000 (256.0) and 0x7FC00000 (NaN) → err = 1, z = 0, neg = 0, done still in cycle 8.
- `clk_en` toggled low for 3 cycles mid-RED, and `start` re-asserted while busy:
  - done arrives 3 cycles later (cycle 11), with the result equal to the un-stalled run.
  - The extra start is ignored, producing no second done.
- `rst` asserted in cycle 4 of an operation → the next cycle shows busy = 0, done = 0, z = 0, neg = 0. No done follows, and a fresh start then completes normally in 8 enabled cycles.
